// File: rtl/btn_debounce_pkg.sv
// btn_debounce_pkg: state encoding and default timing constants for the button debouncer.
package btn_debounce_pkg;
  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_CONF_PRESS = 2'd1,
    S_HELD       = 2'd2,
    S_CONF_REL   = 2'd3
  } state_e;
  localparam int DEF_STABLE_TICKS = 4;
  localparam int DEF_LONG_TICKS   = 50;
  localparam int DEF_REPEAT_TICKS = 10;
endpackage

// File: rtl/btn_debounce_fsm_sync_2ff.sv
// sync_2ff: two-flop synchronizer for an asynchronous input, async active-high reset to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic [1:0] sync_q, sync_d;
  always_comb sync_d = {sync_q[0], d};
  always_ff @(posedge clk or posedge rst)
    if (rst) sync_q <= '0;
    else     sync_q <= sync_d;
  assign q = sync_q[1];
endmodule

// File: rtl/btn_debounce_fsm.sv
// btn_debounce_fsm: tick-qualified push-button debouncer with press/release pulses.
// Optional auto-repeat while held is enabled by defining BTN_AUTO_REPEAT_EN.
module btn_debounce_fsm
  import btn_debounce_pkg::*;
#(
  parameter int STABLE_TICKS = DEF_STABLE_TICKS,
`ifdef BTN_AUTO_REPEAT_EN
  parameter int LONG_TICKS   = DEF_LONG_TICKS,
  parameter int REPEAT_TICKS = DEF_REPEAT_TICKS,
`endif
  parameter int CNT_W        = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       btn_raw,
  output logic       btn_level,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic [1:0] state_o
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_TICKS - 1);
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d, press_q, press_d, rel_q, rel_d;
  logic             btn_s;

  sync_2ff u_sync (.clk(clk), .rst(rst), .d(btn_raw), .q(btn_s));

`ifdef BTN_AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] LONG_V   = CNT_W'(LONG_TICKS);
  localparam logic [CNT_W-1:0] RELOAD_V = CNT_W'(LONG_TICKS - REPEAT_TICKS);
  logic [CNT_W-1:0] hold_q, hold_d, hold_inc;
  assign hold_inc = hold_q + 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
`ifdef BTN_AUTO_REPEAT_EN
    hold_d  = hold_q;
`endif
    if (tick) begin
      case (state_q)
        S_IDLE:
          if (btn_s) begin
            state_d = S_CONF_PRESS;
            cnt_d   = CNT_W'(1);
          end
        S_CONF_PRESS:
          if (!btn_s) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end else if (cnt_q == LAST) begin
            state_d = S_HELD;
            cnt_d   = '0;
            level_d = 1'b1;
            press_d = 1'b1;
          end else cnt_d = cnt_q + 1'b1;
        S_HELD: begin
          if (!btn_s) begin
            state_d = S_CONF_REL;
            cnt_d   = CNT_W'(1);
          end
`ifdef BTN_AUTO_REPEAT_EN
          // Reloading to LONG-REPEAT spaces later pulses REPEAT_TICKS apart.
          hold_d  = !btn_s ? '0 : (hold_inc == LONG_V) ? RELOAD_V : hold_inc;
          press_d = btn_s && (hold_inc == LONG_V);
`endif
        end
        S_CONF_REL:
          if (btn_s) begin
            state_d = S_HELD;
            cnt_d   = '0;
          end else if (cnt_q == LAST) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            level_d = 1'b0;
            rel_d   = 1'b1;
          end else cnt_d = cnt_q + 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
`ifdef BTN_AUTO_REPEAT_EN
      hold_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
      rel_q   <= rel_d;
`ifdef BTN_AUTO_REPEAT_EN
      hold_q  <= hold_d;
`endif
    end

  assign btn_level     = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = rel_q;
  assign state_o       = state_q;
endmodule

// File: tb/tb_btn_debounce_fsm.sv
// tb_btn_debounce_fsm: randomized and directed checks of btn_debounce_fsm against a run-length model.
module tb_btn_debounce_fsm;
  localparam int STABLE = 4;
  localparam int LONG   = 50;
  localparam int REPEAT = 10;
`ifdef BTN_AUTO_REPEAT_EN
  localparam int EXP_HOLD_PRESSES = 4;
`else
  localparam int EXP_HOLD_PRESSES = 1;
`endif

  logic clk = 1'b0, rst = 1'b1, tick = 1'b0, btn_raw = 1'b0;
  logic btn_level, press_pulse, release_pulse;
  logic [1:0] state_o;
  logic [4:0] got;
  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  btn_debounce_fsm dut (
    .clk(clk), .rst(rst), .tick(tick), .btn_raw(btn_raw),
    .btn_level(btn_level), .press_pulse(press_pulse),
    .release_pulse(release_pulse), .state_o(state_o)
  );
  assign got = {btn_level, press_pulse, release_pulse, state_o};

  // Model: accepted level plus length of the current run of tick samples that disagree with it.
  logic [1:0] m_sh;
  logic m_level, m_press, m_rel;
  int m_run, m_held;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_sh <= '0; m_level <= 1'b0; m_press <= 1'b0; m_rel <= 1'b0; m_run <= 0; m_held <= 0;
    end else begin
      m_sh <= {m_sh[0], btn_raw};
      m_press <= 1'b0;
      m_rel <= 1'b0;
      if (tick) begin
        if (m_sh[1] == m_level) m_run <= 0;
        else if (m_run + 1 == STABLE) begin
          m_level <= m_sh[1]; m_run <= 0; m_press <= m_sh[1]; m_rel <= !m_sh[1];
        end else m_run <= m_run + 1;
`ifdef BTN_AUTO_REPEAT_EN
        if (m_level && m_run == 0 && m_sh[1]) begin
          m_held <= m_held + 1;
          if (m_held + 1 >= LONG && (m_held + 1 - LONG) % REPEAT == 0) m_press <= 1'b1;
        end else m_held <= 0;
`endif
      end
    end
  end

  function automatic logic [4:0] exp_vec();
    return {m_level, m_press, m_rel, m_level, m_run != 0};
  endfunction

  task automatic drive(input logic t, input logic b);
    tick = t;
    btn_raw = b;
    @(negedge clk);
  endtask

  task automatic settle();
    for (int i = 0; i < 12; i++) drive(1'b1, 1'b0);
  endtask

  task automatic test_reset();
    tests++;
    if (got !== 5'b0) begin fails++; $display("FAIL reset_hold got %b exp %b", got, 5'b0); end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      drive(1'b1, 1'b0);
      tests++;
      if (got !== 5'b0) begin fails++; $display("FAIL reset_idle c=%0d got %b exp %b", c, got, 5'b0); end
    end
  endtask

  task automatic test_press();
    int press_at = -1, presses = 0;
    settle();
    for (int c = 0; c < 30; c++) begin
      drive(c % 6 == 5, 1'b1);
      if (press_pulse) begin press_at = c; presses++; end
      tests++;
      if (got !== exp_vec()) begin fails++; $display("FAIL press c=%0d got %b exp %b", c, got, exp_vec()); end
    end
    tests++;
    if (press_at != 23 || presses != 1 || btn_level !== 1'b1) begin
      fails++; $display("FAIL press_timing at=%0d n=%0d lvl=%b exp at=23 n=1 lvl=1", press_at, presses, btn_level);
    end
  endtask

  task automatic test_release_bounce();
    int rel_at = -1, rels = 0;
    for (int c = 0; c < 42; c++) begin
      drive(c % 6 == 5, c >= 6 && c < 12);
      if (release_pulse) begin rel_at = c; rels++; end
      tests++;
      if (got !== exp_vec()) begin fails++; $display("FAIL rel_bounce c=%0d got %b exp %b", c, got, exp_vec()); end
      if (c == 11) begin
        tests++;
        if (state_o !== 2'd2) begin fails++; $display("FAIL rel_back_to_held got %0d exp 2", state_o); end
      end
    end
    tests++;
    if (rel_at != 35 || rels != 1 || btn_level !== 1'b0) begin
      fails++; $display("FAIL rel_timing at=%0d n=%0d lvl=%b exp at=35 n=1 lvl=0", rel_at, rels, btn_level);
    end
  endtask

  task automatic test_press_bounce();
    int press_at = -1, presses = 0;
    settle();
    for (int c = 0; c < 40; c++) begin
      drive(c % 6 == 5, c < 6 || c >= 12);
      if (press_pulse) begin press_at = c; presses++; end
      tests++;
      if (got !== exp_vec()) begin fails++; $display("FAIL press_bounce c=%0d got %b exp %b", c, got, exp_vec()); end
    end
    tests++;
    if (press_at != 35 || presses != 1) begin
      fails++; $display("FAIL press_bounce_timing at=%0d n=%0d exp at=35 n=1", press_at, presses);
    end
  endtask

  task automatic test_glitch();
    settle();
    for (int c = 0; c < 120; c++) begin
      drive(c % 6 == 5, (c % 6 != 3) && ($urandom_range(0, 2) == 0));
      tests++;
      if (got !== 5'b0 || got !== exp_vec()) begin
        fails++; $display("FAIL glitch c=%0d got %b exp %b", c, got, exp_vec());
      end
    end
  endtask

  task automatic test_rst_mid();
    settle();
    for (int c = 0; c < 5; c++) drive(1'b1, 1'b1);
    tests++;
    if (state_o !== 2'd1) begin fails++; $display("FAIL rst_pre_state got %0d exp 1", state_o); end
    #2 rst = 1'b1;
    #1;
    tests++;
    if (got !== 5'b0) begin fails++; $display("FAIL rst_async got %b exp %b", got, 5'b0); end
    @(negedge clk);
    btn_raw = 1'b0;
    rst = 1'b0;
    for (int c = 0; c < 15; c++) begin
      drive(1'b1, 1'b0);
      tests++;
      if (press_pulse !== 1'b0 || release_pulse !== 1'b0 || got !== exp_vec()) begin
        fails++; $display("FAIL rst_after c=%0d got %b exp %b", c, got, exp_vec());
      end
    end
  endtask

  task automatic test_random();
    int per = 1;
    logic tgt = 1'b0, prev_p = 1'b0, prev_r = 1'b0;
    settle();
    for (int c = 0; c < 3000; c++) begin
      if (c % 50 == 0) begin per = $urandom_range(1, 4); tgt = 1'($urandom_range(0, 1)); end
      drive(per == 1 ? 1'b1 : (c % per == 0),
            (c % 50 < 25 && $urandom_range(0, 9) < 3) ? !tgt : tgt);
      tests++;
      if (got !== exp_vec() || (press_pulse && release_pulse) || (press_pulse && prev_p) || (release_pulse && prev_r)) begin
        fails++; $display("FAIL random c=%0d got %b exp %b", c, got, exp_vec());
      end
      prev_p = press_pulse;
      prev_r = release_pulse;
    end
  endtask

  task automatic test_long_hold();
    int presses = 0, late = 0, rels = 0;
    settle();
    for (int c = 0; c < 82; c++) begin
      drive(1'b1, 1'b1);
      if (press_pulse) presses++;
      tests++;
      if (got !== exp_vec()) begin fails++; $display("FAIL hold c=%0d got %b exp %b", c, got, exp_vec()); end
    end
    for (int c = 0; c < 20; c++) begin
      drive(1'b1, 1'b0);
      if (press_pulse) late++;
      if (release_pulse) rels++;
      tests++;
      if (got !== exp_vec()) begin fails++; $display("FAIL hold_rel c=%0d got %b exp %b", c, got, exp_vec()); end
    end
    tests++;
    if (presses != EXP_HOLD_PRESSES || late != 0 || rels != 1) begin
      fails++; $display("FAIL hold_counts press=%0d late=%0d rel=%0d exp %0d 0 1", presses, late, rels, EXP_HOLD_PRESSES);
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    test_reset();
    test_press();
    test_release_bounce();
    test_press_bounce();
    test_glitch();
    test_rst_mid();
    test_random();
    test_long_hold();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
